// File: rtl/alu_sequencer.sv
// alu_sequencer: FETCH/DECODE/EXEC/WB sequencer driving an external 8-bit ALU.
// Ports: clk/rst_n; start/prog_len run control; host_* register access;
//        imem_* ROM fetch; alu_* ALU drive/return; busy/done/ovf_err/pc status.

module alu_sequencer #(
    parameter int PC_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [PC_W-1:0] prog_len,
    input  logic            host_wr_en,
    input  logic [1:0]      host_addr,
    input  logic [7:0]      host_wdata,
    output logic [7:0]      host_rdata,
    output logic [PC_W-1:0] imem_addr,
    input  logic [15:0]     imem_data,
    output logic [7:0]      alu_a,
    output logic [7:0]      alu_b,
    output logic [2:0]      alu_s,
    input  logic [7:0]      alu_f,
    input  logic            alu_ovf,
    input  logic            alu_take_branch,
    output logic            busy,
    output logic            done,
    output logic            ovf_err,
    output logic [PC_W-1:0] pc
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB
    } state_t;

    state_t          r_state;
    logic [PC_W-1:0] r_pc;
    logic [15:0]     r_ir;
    logic [7:0]      r_rf [4];
    logic [7:0]      r_a;
    logic [7:0]      r_b;
    logic [2:0]      r_s;
    logic [7:0]      r_f;
    logic            r_ovf;
    logic            r_tb;
    logic            r_done;
    logic            r_ovf_err;

    logic [2:0]      w_op;
    logic [1:0]      w_rd;
    logic            w_is_br;
    logic [PC_W-1:0] w_off;
    logic [PC_W-1:0] w_pc_inc;
    logic [PC_W-1:0] w_pc_next;
    logic            w_ovf_stop;
    logic            w_unused;

    assign w_op       = r_ir[15:13];
    assign w_rd       = r_ir[12:11];
    assign w_is_br    = w_op[2] & w_op[1];
    // 7-bit offset sign-extended to the pc width; wraps mod 2^PC_W.
    assign w_off      = PC_W'($signed(r_ir[6:0]));
    assign w_pc_inc   = r_pc + PC_W'(1);
    assign w_pc_next  = (w_is_br && r_tb) ? (w_pc_inc + w_off) : w_pc_inc;
    assign w_ovf_stop = (w_op == 3'b000) && r_ovf;
    // ra/rb are consumed straight from imem_data when operands are latched.
    assign w_unused   = ^r_ir[10:7];

    assign host_rdata = r_rf[host_addr];
    assign imem_addr  = r_pc;
    assign pc         = r_pc;
    assign alu_a      = r_a;
    assign alu_b      = r_b;
    assign alu_s      = r_s;
    assign busy       = (r_state != S_IDLE);
    assign done       = r_done;
    assign ovf_err    = r_ovf_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_pc      <= '0;
            r_ir      <= '0;
            for (int i = 0; i < 4; i++) begin
                r_rf[i] <= '0;
            end
            r_a       <= '0;
            r_b       <= '0;
            r_s       <= '0;
            r_f       <= '0;
            r_ovf     <= 1'b0;
            r_tb      <= 1'b0;
            r_done    <= 1'b0;
            r_ovf_err <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (host_wr_en) begin
                        r_rf[host_addr] <= host_wdata;
                    end
                    if (start) begin
                        r_pc      <= '0;
                        r_ovf_err <= 1'b0;
                        // An empty program completes without leaving IDLE.
                        if (prog_len == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    r_state <= S_DECODE;
                end
                S_DECODE: begin
                    // Operands registered here so the ALU sees them for all of EXEC.
                    r_ir    <= imem_data;
                    r_a     <= r_rf[imem_data[10:9]];
                    r_b     <= r_rf[imem_data[8:7]];
                    r_s     <= imem_data[15:13];
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    r_f     <= alu_f;
                    r_ovf   <= alu_ovf;
                    r_tb    <= alu_take_branch;
                    r_state <= S_WB;
                end
                S_WB: begin
                    if (!w_is_br) begin
                        r_rf[w_rd] <= r_f;
                    end
                    r_pc <= w_pc_next;
                    if (w_ovf_stop) begin
                        r_ovf_err <= 1'b1;
                    end
                    if (w_ovf_stop || (w_pc_next >= prog_len)) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= S_FETCH;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: random and directed programs for alu_sequencer, checked
// every cycle against an instruction-level model expanded into a cycle trace.

module tb_alu_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  prog_len;
    logic        host_wr_en;
    logic [1:0]  host_addr;
    logic [7:0]  host_wdata;
    logic [7:0]  host_rdata;
    logic [7:0]  imem_addr;
    logic [15:0] imem_data;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [2:0]  alu_s;
    logic [7:0]  alu_f;
    logic        alu_ovf;
    logic        alu_take_branch;
    logic        busy;
    logic        done;
    logic        ovf_err;
    logic [7:0]  pc;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic       busy;
        logic       done;
        logic [7:0] pc;
        logic       ovf;
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] s;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        ce;
    logic [15:0] rom [256];
    logic [7:0]  m_r [4];
    logic [7:0]  cur_a;
    logic [7:0]  cur_b;
    logic [2:0]  cur_s;

    alu_sequencer #(.PC_W(8)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .prog_len        (prog_len),
        .host_wr_en      (host_wr_en),
        .host_addr       (host_addr),
        .host_wdata      (host_wdata),
        .host_rdata      (host_rdata),
        .imem_addr       (imem_addr),
        .imem_data       (imem_data),
        .alu_a           (alu_a),
        .alu_b           (alu_b),
        .alu_s           (alu_s),
        .alu_f           (alu_f),
        .alu_ovf         (alu_ovf),
        .alu_take_branch (alu_take_branch),
        .busy            (busy),
        .done            (done),
        .ovf_err         (ovf_err),
        .pc              (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench-side ALU: {take, ovf, f}
    function automatic logic [9:0] alu_fn(logic [2:0] s, logic [7:0] a,
                                          logic [7:0] b);
        int sa;
        int sb;
        int r;
        logic [7:0] f;
        logic ov;
        logic tk;
        sa = int'($signed(a));
        sb = int'($signed(b));
        ov = 1'b0;
        tk = a[0] ^ b[0];
        case (s)
            3'd0: begin r = sa + sb; f = a + b; ov = (r > 127) || (r < -128); end
            3'd1: begin r = sa - sb; f = a - b; ov = (r > 127) || (r < -128); end
            3'd2: f = a & b;
            3'd3: f = a | b;
            3'd4: f = a ^ b;
            3'd5: f = {a[6:0], 1'b0};
            3'd6: begin f = a - b; tk = (a == b); end
            default: begin f = a - b; tk = (a != b); end
        endcase
        return {tk, ov, f};
    endfunction

    always_comb begin
        {alu_take_branch, alu_ovf, alu_f} = alu_fn(alu_s, alu_a, alu_b);
    end

    always @(posedge clk) imem_data <= rom[imem_addr];

    function automatic logic [15:0] enc(logic [2:0] op, logic [1:0] rd,
                                        logic [1:0] ra, logic [1:0] rb,
                                        logic [6:0] off);
        return {op, rd, ra, rb, off};
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Per-cycle compare against the expected trace.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            ce = exp_q.pop_front();
            n_assert++;
            if ({busy, done, pc, imem_addr, ovf_err, alu_a, alu_b, alu_s} !==
                {ce.busy, ce.done, ce.pc, ce.pc, ce.ovf, ce.a, ce.b, ce.s}) begin
                n_fail++;
                $display("FAIL trace t=%0t: got busy=%b done=%b pc=%0h ia=%0h ovf=%b a=%0h b=%0h s=%0h, expected busy=%b done=%b pc=%0h ovf=%b a=%0h b=%0h s=%0h",
                         $time, busy, done, pc, imem_addr, ovf_err, alu_a,
                         alu_b, alu_s, ce.busy, ce.done, ce.pc, ce.ovf,
                         ce.a, ce.b, ce.s);
            end
        end
    end

    // Instruction-level execution; each instruction contributes 4 busy
    // cycles, then two idle cycles (first with done).
    task automatic model_run(input logic [7:0] plen, input bit wr,
                             input logic [1:0] wa, input logic [7:0] wd,
                             input bit commit, output bit ok);
        logic [7:0]  lr [4];
        logic [7:0]  la;
        logic [7:0]  lb;
        logic [2:0]  ls;
        logic [7:0]  p;
        logic [15:0] ins;
        logic [9:0]  res;
        logic        ovf_flag;
        int          o;
        exp_t        e;
        exp_t        tq[$];
        for (int i = 0; i < 4; i++) lr[i] = m_r[i];
        if (wr) lr[wa] = wd;
        la = cur_a;
        lb = cur_b;
        ls = cur_s;
        p = 8'd0;
        ovf_flag = 1'b0;
        ok = 1'b1;
        if (plen != 0) begin
            ok = 1'b0;
            for (int n = 0; n < 30; n++) begin
                ins = rom[p];
                e.busy = 1'b1; e.done = 1'b0; e.pc = p; e.ovf = 1'b0;
                e.a = la; e.b = lb; e.s = ls;
                tq.push_back(e);
                tq.push_back(e);
                la = lr[ins[10:9]];
                lb = lr[ins[8:7]];
                ls = ins[15:13];
                e.a = la; e.b = lb; e.s = ls;
                tq.push_back(e);
                tq.push_back(e);
                res = alu_fn(ls, la, lb);
                if (ls >= 3'd6) begin
                    if (res[9]) begin
                        o = ins[6] ? int'(ins[6:0]) - 128 : int'(ins[6:0]);
                        p = 8'(int'(p) + 1 + o);
                    end else begin
                        p = p + 8'd1;
                    end
                end else begin
                    lr[ins[12:11]] = res[7:0];
                    p = p + 8'd1;
                end
                if (ls == 3'd0 && res[8]) begin
                    ovf_flag = 1'b1;
                    ok = 1'b1;
                    break;
                end
                if (p >= plen) begin
                    ok = 1'b1;
                    break;
                end
            end
        end
        e.busy = 1'b0; e.done = 1'b1; e.pc = p; e.ovf = ovf_flag;
        e.a = la; e.b = lb; e.s = ls;
        tq.push_back(e);
        e.done = 1'b0;
        tq.push_back(e);
        if (ok && commit) begin
            for (int i = 0; i < 4; i++) m_r[i] = lr[i];
            cur_a = la;
            cur_b = lb;
            cur_s = ls;
            foreach (tq[i]) exp_q.push_back(tq[i]);
        end
    endtask

    task automatic hwr(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        #1;
        host_wr_en = 1'b1;
        host_addr  = a;
        host_wdata = d;
        m_r[a]     = d;
        @(posedge clk);
        #1;
        host_wr_en = 1'b0;
    endtask

    task automatic check_regs(input string nm);
        for (int r = 0; r < 4; r++) begin
            host_addr = 2'(r);
            #1;
            chk(nm, {22'd0, 2'(r), host_rdata}, {22'd0, 2'(r), m_r[r]});
        end
    endtask

    task automatic run(input logic [7:0] plen, input bit noise, input bit wr,
                       input logic [1:0] wa, input logic [7:0] wd);
        bit ok;
        int budget;
        @(negedge clk);
        #1;
        prog_len = plen;
        start = 1'b1;
        if (wr) begin
            host_wr_en = 1'b1;
            host_addr  = wa;
            host_wdata = wd;
        end
        model_run(plen, wr, wa, wd, 1'b1, ok);
        @(posedge clk);
        #1;
        start = 1'b0;
        host_wr_en = 1'b0;
        budget = exp_q.size() + 5;
        while (exp_q.size() > 0 && budget > 0) begin
            @(negedge clk);
            #1;
            budget--;
            if (noise && exp_q.size() >= 2) begin
                start      = 1'($urandom);
                host_wr_en = 1'($urandom);
                host_addr  = 2'($urandom);
                host_wdata = 8'($urandom);
            end else begin
                start      = 1'b0;
                host_wr_en = 1'b0;
            end
        end
        start = 1'b0;
        host_wr_en = 1'b0;
        if (exp_q.size() > 0) begin
            n_assert++;
            n_fail++;
            $display("FAIL run_timeout: %0d trace cycles left", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_r[i] = 8'd0;
        cur_a = 8'd0;
        cur_b = 8'd0;
        cur_s = 3'd0;
    endtask

    initial begin
        bit ok;
        logic [7:0] plen;
        bit wr;
        logic [1:0] wa;
        logic [7:0] wd;

        for (int i = 0; i < 256; i++) rom[i] = 16'd0;
        model_reset();
        rst_n = 1'b0;
        start = 1'b0;
        prog_len = 8'd0;
        host_wr_en = 1'b0;
        host_addr = 2'd0;
        host_wdata = 8'd0;

        #12;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_ovf_err", ovf_err, 1'b0);
        chk("rst_pc", pc, 8'd0);
        chk("rst_alu", {alu_a, alu_b, alu_s}, 19'd0);
        check_regs("rst_reg");
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        // Overflowing ADD
        hwr(2'd1, 8'h4E);
        hwr(2'd2, 8'h65);
        rom[0] = enc(3'd0, 2'd0, 2'd1, 2'd2, 7'd0);
        run(8'd1, 1'b0, 1'b0, 2'd0, 8'd0);
        host_addr = 2'd0;
        #1;
        chk("ovf_R0_lit", host_rdata, 8'hB3);
        chk("ovf_err_lit", ovf_err, 1'b1);
        chk("ovf_pc_lit", pc, 8'd1);
        check_regs("ovf_reg");

        // Logic ops
        hwr(2'd1, 8'h31);
        hwr(2'd2, 8'h35);
        rom[0] = enc(3'd2, 2'd3, 2'd1, 2'd2, 7'd0);
        rom[1] = enc(3'd3, 2'd0, 2'd1, 2'd2, 7'd0);
        run(8'd2, 1'b0, 1'b0, 2'd0, 8'd0);
        host_addr = 2'd3;
        #1;
        chk("and_R3_lit", host_rdata, 8'h31);
        host_addr = 2'd0;
        #1;
        chk("or_R0_lit", host_rdata, 8'h35);
        chk("logic_ovf_lit", ovf_err, 1'b0);

        // Branches: BNE falls through, BEQ taken to 5
        hwr(2'd1, 8'h86);
        hwr(2'd2, 8'h86);
        rom[0] = enc(3'd7, 2'd0, 2'd1, 2'd2, 7'd5);
        rom[1] = enc(3'd6, 2'd0, 2'd1, 2'd2, 7'd3);
        run(8'd5, 1'b0, 1'b0, 2'd0, 8'd0);
        chk("br_pc_lit", pc, 8'd5);
        check_regs("br_reg");

        // Negative offset wraps pc past prog_len
        rom[0] = enc(3'd6, 2'd0, 2'd0, 2'd0, 7'h40);
        run(8'd4, 1'b0, 1'b0, 2'd0, 8'd0);
        chk("wrap_pc_lit", pc, 8'hC1);

        // Empty program
        run(8'd0, 1'b0, 1'b0, 2'd0, 8'd0);
        chk("plen0_pc_lit", pc, 8'd0);

        // start/host_wr_en noise while busy
        rom[0] = enc(3'd1, 2'd3, 2'd1, 2'd0, 7'd0);
        rom[1] = enc(3'd4, 2'd2, 2'd3, 2'd1, 7'd0);
        rom[2] = enc(3'd5, 2'd1, 2'd2, 2'd2, 7'd0);
        run(8'd3, 1'b1, 1'b0, 2'd0, 8'd0);
        check_regs("noise_reg");

        // Host write in the same cycle as start
        run(8'd3, 1'b0, 1'b1, 2'd1, 8'h5A);
        check_regs("wrstart_reg");

        // Reset in EXEC of the second instruction
        rom[0] = enc(3'd2, 2'd3, 2'd1, 2'd2, 7'd0);
        rom[1] = enc(3'd2, 2'd0, 2'd1, 2'd2, 7'd0);
        rom[2] = enc(3'd3, 2'd1, 2'd1, 2'd2, 7'd0);
        @(negedge clk);
        #1;
        prog_len = 8'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) @(negedge clk);
        chk("mid_busy", busy, 1'b1);
        chk("mid_exec_pc", pc, 8'd1);
        chk("mid_exec_s", alu_s, 3'd2);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_pc", pc, 8'd0);
        chk("mid_rst_alu", {alu_a, alu_b, alu_s}, 19'd0);
        check_regs("mid_rst_reg");
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("mid_no_done", {busy, done}, 2'b00);
        end
        hwr(2'd1, 8'h0F);
        hwr(2'd2, 8'hF3);
        run(8'd3, 1'b0, 1'b0, 2'd0, 8'd0);
        check_regs("post_rst_reg");

        // Random programs
        for (int t = 0; t < 25; t++) begin
            for (int r = 0; r < 4; r++) begin
                if ($urandom_range(0, 1) == 1) hwr(2'(r), 8'($urandom));
            end
            plen = 8'($urandom_range(1, 12));
            wr = (t % 3 == 0);
            wa = 2'($urandom);
            wd = 8'($urandom);
            ok = 1'b0;
            for (int k = 0; k < 20 && !ok; k++) begin
                for (int i = 0; i < 16; i++) rom[i] = 16'($urandom);
                model_run(plen, wr, wa, wd, 1'b0, ok);
            end
            if (!ok) begin
                for (int i = 0; i < 16; i++) rom[i][6:0] = 7'd0;
            end
            run(plen, (t % 2 == 1), wr, wa, wd);
            check_regs("rand_reg");
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
